// File: rtl/cpu5_mc_controller.sv
// Multicycle sequencing controller for the cpu5 core: steps each instruction through
// fetch/decode/execute/memory/writeback over one shared single-port memory.
module cpu5_mc_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       illegal,
    output logic [3:0] state_dbg
);
    // state  | meaning
    // FETCH  | request instruction at PC, PC+4 on completion
    // DECODE | dispatch on opcode, latch branch target
    // MEMADR | compute load/store address
    // MEMRD  | load data access
    // MEMWB  | write memory data to register file
    // MEMWR  | store data access
    // EXEC   | R-type ALU operation
    // ALUWB  | write ALU result to register file
    // BRANCH | compare, redirect PC on zero
    // JUMP   | redirect PC to jump target
    // IEXEC  | I-type ALU operation

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic [1:0] pcsrc;
        logic       regwrite;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic       pcen_uncond;
        logic       is_fetch;
        logic       is_decode;
        logic       is_branch;
    } ctl_t;

    state_t state;
    state_t state_nxt;
    ctl_t   ctl_q;
    logic   op_supported;

    function automatic ctl_t decode_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req  = 1'b1;
                c.alusrcb  = 2'b01;
                c.is_fetch = 1'b1;
            end
            S_DECODE: begin
                c.alusrcb   = 2'b10;
                c.is_decode = 1'b1;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
            end
            S_MEMRD: begin
                c.mem_req = 1'b1;
                c.iord    = 1'b1;
            end
            S_MEMWB: begin
                c.regwrite = 1'b1;
                c.memtoreg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req  = 1'b1;
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXEC: begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b10;
            end
            S_IEXEC: begin
                c.alusrca = 1'b1;
                c.alusrcb = 2'b10;
                c.aluop   = 2'b10;
            end
            S_ALUWB: c.regwrite = 1'b1;
            S_BRANCH: begin
                c.alusrca   = 1'b1;
                c.aluop     = 2'b01;
                c.pcsrc     = 2'b01;
                c.is_branch = 1'b1;
            end
            S_JUMP: begin
                c.pcsrc       = 2'b10;
                c.pcen_uncond = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        op_supported = (op == OP_RTYPE) || (op == OP_ITYPE) || (op == OP_LOAD) ||
                       (op == OP_STORE) || (op == OP_BRANCH) || (op == OP_JAL);
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:          state_nxt = S_EXEC;
                    OP_ITYPE:          state_nxt = S_IEXEC;
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JUMP;
                    default:           state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LOAD)
                    state_nxt = S_MEMRD;
                else if (op == OP_STORE)
                    state_nxt = S_MEMWR;
                else
                    state_nxt = S_FETCH;
            end
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_IEXEC:  state_nxt = S_ALUWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Control word is registered alongside the state so Moore outputs come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
            ctl_q <= decode_ctl(S_FETCH);
        end else begin
            state <= state_nxt;
            ctl_q <= decode_ctl(state_nxt);
        end
    end

    // Strobes that could disturb the datapath are masked while reset is held.
    assign mem_req   = ctl_q.mem_req  & ~reset;
    assign memwrite  = ctl_q.memwrite & ~reset;
    assign regwrite  = ctl_q.regwrite & ~reset;
    assign irwrite   = ctl_q.is_fetch & mem_ready & ~reset;
    assign pcen      = ((ctl_q.is_fetch & mem_ready) | (ctl_q.is_branch & zero) |
                        ctl_q.pcen_uncond) & ~reset;
    assign illegal   = ctl_q.is_decode & ~op_supported & ~reset;
    assign iord      = ctl_q.iord;
    assign pcsrc     = ctl_q.pcsrc;
    assign memtoreg  = ctl_q.memtoreg;
    assign alusrca   = ctl_q.alusrca;
    assign alusrcb   = ctl_q.alusrcb;
    assign aluop     = ctl_q.aluop;
    assign state_dbg = state;
endmodule

// File: doc/cpu5_mc_controller.md
# cpu5_mc_controller

Multicycle sequencing controller for the cpu5 core. It replaces the single-cycle main/ALU decode path when instruction fetch and data access share one single-port memory with a request/ready handshake. A Moore-style state machine steps each instruction through fetch, decode, execute, memory and writeback. It drives the shared-datapath enables, the multiplexer selects and the memory request.

## Interface
- No parameters. Widths come from `defines.v`: `CPU5_OPCODE_SIZE`=7, `CPU5_FUNCT7_SIZE`, `CPU5_ALU_OP_SIZE`=2.
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  7  opcode field of the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request; held until accepted.
- memwrite  output  1  access is a write; valid while mem_req=1.
- iord  output  1  memory address select: 0 = PC, 1 = ALU result register.
- irwrite  output  1  load the instruction register.
- pcen  output  1  PC register enable.
- pcsrc  output  2  PC source: 00 = ALU, 01 = ALU result register, 10 = jump target.
- regwrite  output  1  register file write enable.
- memtoreg  output  1  writeback data select: 1 = memory data register, 0 = ALU result register.
- alusrca  output  1  ALU A select: 0 = PC, 1 = rs1.
- alusrcb  output  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- aluop  output  2  ALU decode class: 00 = add, 01 = sub, 10 = use funct.
- illegal  output  1  one-cycle pulse on an unsupported opcode.
- state_dbg  output  4  current state encoding.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10. Encodings 11–15 are unreachable and go to FETCH on the next edge.
- Every output not listed for a state is 0. pcsrc, alusrca, alusrcb and aluop default to 00/0.
- **FETCH:** mem_req=1, iord=0, alusrcb=01, aluop=00.
  - When mem_ready=1: irwrite=1, pcen=1 (PC+4); next state DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** alusrcb=10 (PC+imm branch target is latched into the ALU result register). Next state by op:
  - 0110011 → EXEC
  - 0010011 → IEXEC
  - 0000011 or 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 → JUMP
  - any other opcode → illegal=1, next state FETCH.
- **MEMADR:** alusrca=1, alusrcb=10. Next state MEMRD for a load, MEMWR for a store.
- **MEMRD:** mem_req=1, iord=1. When mem_ready=1, next state MEMWB; otherwise stay.
- **MEMWB:** regwrite=1, memtoreg=1. Next state FETCH.
- **MEMWR:** mem_req=1, memwrite=1, iord=1. When mem_ready=1, next state FETCH; otherwise stay.
- **EXEC:** alusrca=1, alusrcb=00, aluop=10. Next state ALUWB.
- **IEXEC:** alusrca=1, alusrcb=10, aluop=10. Next state ALUWB.
- **ALUWB:** regwrite=1, memtoreg=0. Next state FETCH.
- **BRANCH:** alusrca=1, alusrcb=00, aluop=01, pcsrc=01, pcen=zero. Next state FETCH.
- **JUMP:** pcsrc=10, pcen=1; no link write. Next state FETCH.
- The opcode is sampled from the instruction register in DECODE and MEMADR. The IR is stable from DECODE onward because irwrite is asserted only in FETCH.

## Timing
- Reset:
  - State is forced to FETCH immediately and asynchronously.
  - While reset=1, mem_req, irwrite, pcen, regwrite, memwrite and illegal are forced to 0 combinationally.
  - All other outputs take their FETCH values; state_dbg=0.
  - The first fetch request is asserted in the first cycle after reset deasserts.
- Output timing:
  - irwrite and pcen in FETCH, and pcen in BRANCH, are Mealy terms (depend on mem_ready / zero).
  - All other outputs decode from the state register only.
- Cycles per instruction with mem_ready=1 on first request: R/I-ALU 4, load 5, store 4, branch 3, jump 3, illegal 2.
- Each cycle of mem_ready=0 while mem_req=1 adds one stall cycle.
- Handshake:
  - A transfer completes on a rising edge where mem_req=1 and mem_ready=1.
  - mem_req, memwrite and iord are stable from assertion until that edge.
  - mem_ready while mem_req=0 is ignored.
- Reset mid-access abandons the access. mem_req drops in the same cycle.

## Test plan
- Reset then mem_ready=1, op=0110011 → state_dbg 0,1,6,7,0. regwrite=1 only in ALUWB (memtoreg=0). pcen=1 once.
- op=0000011, mem_ready low for 3 cycles during MEMRD → state stays 3 for 3 cycles with mem_req=1, iord=1. Then MEMWB with regwrite=1, memtoreg=1. Total 8 cycles.
- op=0100011 → MEMWR with mem_req=1, memwrite=1, iord=1. No regwrite at any point. Returns to FETCH after 4 cycles.
- op=1100011, zero=1 then zero=0 → BRANCH with pcsrc=01, aluop=01. pcen=1 in the first case, 0 in the second.
- op=1111111 → illegal pulses for exactly one cycle in DECODE. Next state FETCH. No regwrite or memwrite.
- Reset asserted while in MEMRD with mem_req=1 → mem_req=0 and state_dbg=0 in the same cycle. Next fetch is issued after release.
